// File: rtl/tel_pkg.sv
// tel_pkg: shared constants and state types for the tell message UART serializer
//   TAG_STATUS/TAG_SENT  frame tag characters for the status and sent channels
//   ASCII_*              fixed frame punctuation
//   FRAME_BYTES          bytes per transmitted line
package tel_pkg;
   localparam logic [7:0] TAG_STATUS  = 8'h53;
   localparam logic [7:0] TAG_SENT    = 8'h4D;
   localparam logic [7:0] ASCII_COLON = 8'h3A;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam int FRAME_BYTES = 12;
   typedef enum logic [1:0] {IDLE, LOAD, SEND} topState_t;
   typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byteState_t;
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte transmitter with back-to-back restart
//   clk, rst   clock and synchronous active-high reset
//   start      pulse; accepted when idle or in the done cycle
//   data       byte to send, LSB first
//   txd        serial line, idle high
//   done       high in the last cycle of the stop bit
module uart_tx_byte #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   output logic       txd,
   output logic       done
);
   import tel_pkg::*;
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   byteState_t state;
   logic [CW-1:0] cnt;
   logic [2:0] bitIdx;
   logic [7:0] sh;
   logic bitEnd;
   assign bitEnd = cnt == CW'(CLKS_PER_BIT - 1);
   assign done = state == B_STOP && bitEnd;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= B_IDLE;
         cnt <= '0;
         bitIdx <= '0;
         sh <= '0;
         txd <= 1'b1;
      end else if (start && (state == B_IDLE || done)) begin
         state <= B_START;
         cnt <= '0;
         bitIdx <= '0;
         sh <= data;
         txd <= 1'b0;
      end else if (state != B_IDLE) begin
         cnt <= bitEnd ? '0 : cnt + 1'b1;
         if (bitEnd) begin
            case (state)
               B_START: begin
                  state <= B_DATA;
                  txd <= sh[0];
               end
               B_DATA: begin
                  bitIdx <= bitIdx + 1'b1;
                  sh <= sh >> 1;
                  state <= bitIdx == 3'd7 ? B_STOP : B_DATA;
                  txd <= bitIdx == 3'd7 ? 1'b1 : sh[1];
               end
               default: begin
                  state <= B_IDLE;
                  txd <= 1'b1;
               end
            endcase
         end
      end
   end
endmodule

// File: rtl/tel_msg_uart.sv
// tel_msg_uart: sends "S:<status>\r\n" / "M:<sent>\r\n" lines over UART whenever a tell output changes
//   clk, rst    clock and synchronous active-high reset
//   statusMsg   8-char status text, leftmost char in [63:56]
//   sentMsg     8-char message/cost text, same byte order
//   txd         UART 8N1 line, idle high
//   busy        high from LOAD until the last stop bit has ended
//   overrun     one-cycle pulse when a channel changes while already pending
module tel_msg_uart #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] statusMsg,
   input  logic [63:0] sentMsg,
   output logic        txd,
   output logic        busy,
   output logic        overrun
);
   import tel_pkg::*;
   topState_t state;
   logic [63:0] shS, shM;
   logic [95:0] frame;
   logic [3:0] idx;
   logic pendS, pendM, chanM;
   logic chgS, chgM, loadS, loadM, lastByte, byteStart, byteDone;
   logic [7:0] tag, byteData;
   assign chgS = statusMsg != shS;
   assign chgM = sentMsg != shM;
   assign loadS = state == LOAD && !chanM;
   assign loadM = state == LOAD && chanM;
   assign tag = chanM ? TAG_SENT : TAG_STATUS;
   assign lastByte = idx == 4'(FRAME_BYTES - 1);
   // The tag goes out straight from LOAD; later bytes come from the rotating frame buffer,
   // whose next byte always sits just below the byte currently on the line.
   assign byteStart = state == LOAD || (state == SEND && byteDone && !lastByte);
   assign byteData = state == LOAD ? tag : frame[87:80];
   uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) uTx (
      .clk  (clk),
      .rst  (rst),
      .start(byteStart),
      .data (byteData),
      .txd  (txd),
      .done (byteDone)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         shS <= '0;
         shM <= '0;
         pendS <= 1'b0;
         pendM <= 1'b0;
         chanM <= 1'b0;
         frame <= '0;
         idx <= '0;
         busy <= 1'b0;
         overrun <= 1'b0;
      end else begin
         shS <= statusMsg;
         shM <= sentMsg;
         // A change landing in the LOAD cycle re-arms the flag; the old shadow is what gets framed.
         pendS <= chgS || (pendS && !loadS);
         pendM <= chgM || (pendM && !loadM);
         overrun <= (chgS && pendS && !loadS) || (chgM && pendM && !loadM);
         case (state)
            IDLE: if (pendS || pendM) begin
               state <= LOAD;
               chanM <= !pendS;
               busy <= 1'b1;
            end
            LOAD: begin
               state <= SEND;
               idx <= '0;
               frame <= {tag, ASCII_COLON, (chanM ? shM : shS), ASCII_CR, ASCII_LF};
            end
            default: if (byteDone) begin
               frame <= {frame[87:0], frame[95:88]};
               idx <= idx + 1'b1;
               if (lastByte) begin
                  state <= IDLE;
                  busy <= 1'b0;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_tel_msg_uart.sv
// tb_tel_msg_uart: scoreboard bench; stimulus pushes expected lines, a UART receiver pops and compares
module tb_tel_msg_uart;
   localparam int CPB = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [63:0] statusMsg = '0;
   logic [63:0] sentMsg = '0;
   logic txd, busy, overrun;
   int tests = 0;
   int fails = 0;
   int ovCount = 0;
   logic [95:0] expQ[$];

   tel_msg_uart #(.CLKS_PER_BIT(CPB)) dut (
      .clk      (clk),
      .rst      (rst),
      .statusMsg(statusMsg),
      .sentMsg  (sentMsg),
      .txd      (txd),
      .busy     (busy),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   function automatic logic [95:0] frm(input logic [7:0] tag, input logic [63:0] m);
      return {tag, 8'h3A, m, 8'h0D, 8'h0A};
   endfunction

   function automatic logic [63:0] randMsg(input logic [63:0] old);
      logic [63:0] m;
      do begin
         m = '0;
         for (int i = 0; i < 8; i++) m = {m[55:0], 8'(8'h20 + $urandom_range(0, 94))};
      end while (m == old);
      return m;
   endfunction

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int i = 0;
      while (expQ.size() != 0 && i < 4000) begin
         tick(1);
         i++;
      end
      check("drainTimeout", 96'(expQ.size()), 96'd0);
      tick(8);
      check("busyIdle", 96'(busy), 96'd0);
   endtask

   always @(negedge clk) if (overrun === 1'b1) ovCount++;

   // Receiver: samples every cycle of every bit, demands each bit be flat for CPB cycles.
   initial begin : rxMon
      logic [95:0] rxFrame;
      logic [7:0] b;
      logic cur, shapeOk, aborted;
      int nRx;
      rxFrame = '0;
      nRx = 0;
      forever begin
         @(negedge clk);
         if (rst) nRx = 0;
         else if (txd === 1'b0) begin
            shapeOk = 1'b1;
            aborted = 1'b0;
            b = '0;
            cur = 1'b0;
            for (int k = 0; k < 10 * CPB && !aborted; k++) begin
               if (k > 0) @(negedge clk);
               if (rst) aborted = 1'b1;
               else if (k % CPB == 0) cur = txd;
               else if (txd !== cur) shapeOk = 1'b0;
               if (!aborted && k % CPB == CPB - 1) begin
                  if (k / CPB == 0) shapeOk &= cur == 1'b0;
                  else if (k / CPB == 9) shapeOk &= cur == 1'b1;
                  else b[k / CPB - 1] = cur;
               end
            end
            if (aborted) nRx = 0;
            else begin
               check("byteShape", 96'(shapeOk), 96'd1);
               rxFrame = {rxFrame[87:0], b};
               nRx++;
               if (nRx == 12) begin
                  nRx = 0;
                  check("frameExpected", 96'(expQ.size() != 0), 96'd1);
                  if (expQ.size() != 0) check("frameData", rxFrame, expQ.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL globalTimeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int ov0;
      logic [63:0] s, m;
      tick(3);
      check("resetTxd", 96'(txd), 96'd1);
      check("resetBusy", 96'(busy), 96'd0);
      check("resetOverrun", 96'(overrun), 96'd0);
      rst = 1'b0;
      tick(5);
      // first frame and its exact timing
      ov0 = ovCount;
      statusMsg = "IDLE    ";
      expQ.push_back(frm(8'h53, "IDLE    "));
      tick(1);
      check("busyBeforeLoad", 96'(busy), 96'd0);
      tick(1);
      check("busyAtLoad", 96'(busy), 96'd1);
      check("txdAtLoad", 96'(txd), 96'd1);
      tick(1);
      check("startBitEdge", 96'(txd), 96'd0);
      tick(479);
      check("busyLastCycle", 96'(busy), 96'd1);
      tick(1);
      check("busyFall", 96'(busy), 96'd0);
      drain();
      tick(600);
      check("overrunNone1", 96'(ovCount - ov0), 96'd0);
      // simultaneous change: S first then M
      ov0 = ovCount;
      statusMsg = "RINGING ";
      sentMsg = "       T";
      expQ.push_back(frm(8'h53, "RINGING "));
      expQ.push_back(frm(8'h4D, "       T"));
      drain();
      check("overrunNone2", 96'(ovCount - ov0), 96'd0);
      // three M changes during an S frame: two overruns, newest kept
      ov0 = ovCount;
      statusMsg = "ANSWER  ";
      expQ.push_back(frm(8'h53, "ANSWER  "));
      tick(100);
      sentMsg = "      TE";
      tick(20);
      sentMsg = "     TER";
      tick(20);
      sentMsg = "    TERM";
      expQ.push_back(frm(8'h4D, "    TERM"));
      drain();
      check("overrunTwice", 96'(ovCount - ov0), 96'd2);
      // S change while S is on the line
      ov0 = ovCount;
      statusMsg = "CALLER  ";
      expQ.push_back(frm(8'h53, "CALLER  "));
      tick(150);
      statusMsg = "CALLEE  ";
      expQ.push_back(frm(8'h53, "CALLEE  "));
      drain();
      check("overrunNone4", 96'(ovCount - ov0), 96'd0);
      // cost line
      statusMsg = "COST    ";
      sentMsg = "00000021";
      expQ.push_back(frm(8'h53, "COST    "));
      expQ.push_back(frm(8'h4D, "00000021"));
      drain();
      // reset during byte 5: frame abandoned, current inputs re-sent
      statusMsg = "DIALING ";
      expQ.push_back(frm(8'h53, "DIALING "));
      tick(213);
      rst = 1'b1;
      tick(1);
      check("midResetTxd", 96'(txd), 96'd1);
      check("midResetBusy", 96'(busy), 96'd0);
      rst = 1'b0;
      expQ.delete();
      expQ.push_back(frm(8'h53, "DIALING "));
      expQ.push_back(frm(8'h4D, "00000021"));
      drain();
      // randomized changes; M may land anywhere relative to the S frame
      for (int it = 0; it < 10; it++) begin
         int mode;
         mode = int'($urandom_range(1, 4));
         s = randMsg(statusMsg);
         m = randMsg(sentMsg);
         if (mode == 4) begin
            statusMsg = s;
            expQ.push_back(frm(8'h53, s));
            tick(int'($urandom_range(10, 600)));
            sentMsg = m;
            expQ.push_back(frm(8'h4D, m));
         end else begin
            if (mode[0]) begin
               statusMsg = s;
               expQ.push_back(frm(8'h53, s));
            end
            if (mode[1]) begin
               sentMsg = m;
               expQ.push_back(frm(8'h4D, m));
            end
         end
         drain();
      end
      tick(600);
      check("queueEmptyEnd", 96'(expQ.size()), 96'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
